// File: rtl/arb_pkg.sv
// Shared arbiter types: FSM state encoding and transfer-counter width.
package arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mux2.sv
// Two-input payload multiplexer: sel=0 passes x, sel=1 passes y.
module mux2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sel,
    output logic [N-1:0] z
);

    assign z = sel ? y : x;

endmodule

// File: rtl/bus_arbiter2.sv
// Two-requester arbiter with round-robin tie-break feeding one registered
// valid/ready output stage; counts completed output transfers.
module bus_arbiter2
    import arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [N-1:0]     data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [N-1:0]     data1,
    output logic             gnt1,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             owner,
    output logic [CNT_W-1:0] xfer_count
);

    state_t         state, state_nxt;
    logic           prio;
    logic           winner;
    logic           accept;
    logic           drain;
    logic [N-1:0]   sel_data;

    // Tie goes to prio; a lone request wins outright.
    assign winner = (req0 && req1) ? prio : req1;
    assign drain  = (state == HOLD) && out_ready;
    // Reset gating keeps grants low while rst is high.
    assign accept = !rst && ((state == IDLE) || out_ready) && (req0 || req1);
    assign gnt0   = accept && !winner;
    assign gnt1   = accept && winner;
    assign out_valid = (state == HOLD);

    mux2 #(.N(N)) u_mux (
        .x   (data0),
        .y   (data1),
        .sel (winner),
        .z   (sel_data)
    );

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = HOLD;
        else if (drain)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_data   <= '0;
            owner      <= 1'b0;
            prio       <= 1'b0;
            xfer_count <= '0;
        end else begin
            state <= state_nxt;
            if (drain)
                xfer_count <= xfer_count + 1'b1;
            if (accept) begin
                out_data <= sel_data;
                owner    <= winner;
                prio     <= !winner;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: reset, single grant, contention,
// backpressure, idle ready, mid-transfer reset and counter wrap.
module tb_bus_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        owner;
    logic [15:0] xfer_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arbiter2 #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .data0      (data0),
        .gnt0       (gnt0),
        .req1       (req1),
        .data1      (data1),
        .gnt1       (gnt1),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .owner      (owner),
        .xfer_count (xfer_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b0;
        data0 = 32'h0; data1 = 32'h0;
        step(); step();
        #1;
        n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got=%b exp=00", {gnt0, gnt1}); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        n_cmp++; if (xfer_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
        n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
    endtask

    task automatic test_single();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b0; data0 = 32'hcafebabe; out_ready = 1'b1;
        #1;
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL single_gnt got=%b exp=10", {gnt0, gnt1}); end
        step();
        req0 = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== 32'hcafebabe) begin n_bad++; $display("FAIL single_data got=%h exp=cafebabe", out_data); end
        n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL single_owner got=%b exp=0", owner); end
        step();
        n_cmp++; if (xfer_count !== 16'd1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", xfer_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 32'hcafebabe) begin n_bad++; $display("FAIL single_keep got=%h exp=cafebabe", out_data); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hcafebabe; exp_d[1] = 32'hdeadbeef;
        exp_d[2] = 32'hcafebabe; exp_d[3] = 32'hdeadbeef;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        data0 = 32'hcafebabe; data1 = 32'hdeadbeef; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL contend_gnt[%0d] got=%b exp=%b", i, {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
            n_cmp++;
            if (out_data !== exp_d[i]) begin
                n_bad++; $display("FAIL contend_data[%0d] got=%h exp=%h", i, out_data, exp_d[i]);
            end
        end
        n_cmp++; if (xfer_count !== 16'd3) begin n_bad++; $display("FAIL contend_count got=%0d exp=3", xfer_count); end
    endtask

    // Entered in HOLD with deadbeef from requester 1 and prio back on 0.
    task automatic test_backpressure();
        req0 = 1'b0; req1 = 1'b1; data1 = 32'h12345678; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_bad++; $display("FAIL bp_gnt[%0d] got=%b exp=00", i, {gnt0, gnt1}); end
            step();
            n_cmp++;
            if (out_data !== 32'hdeadbeef || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold[%0d] got=%h/%b exp=deadbeef/1", i, out_data, out_valid);
            end
        end
        n_cmp++; if (xfer_count !== 16'd3) begin n_bad++; $display("FAIL bp_count got=%0d exp=3", xfer_count); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL bp_release_gnt got=%b exp=01", {gnt0, gnt1}); end
        step();
        req1 = 1'b0;
        n_cmp++; if (out_data !== 32'h12345678) begin n_bad++; $display("FAIL bp_new_data got=%h exp=12345678", out_data); end
        n_cmp++; if (owner !== 1'b1) begin n_bad++; $display("FAIL bp_owner got=%b exp=1", owner); end
        n_cmp++; if (xfer_count !== 16'd4) begin n_bad++; $display("FAIL bp_count2 got=%0d exp=4", xfer_count); end
        step();
        n_cmp++; if (xfer_count !== 16'd5) begin n_bad++; $display("FAIL bp_drain_count got=%0d exp=5", xfer_count); end
        // out_ready high while idle must not count
        step();
        n_cmp++; if (xfer_count !== 16'd5 || out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ready got=%0d/%b exp=5/0", xfer_count, out_valid); end
    endtask

    task automatic test_mid_reset();
        req0 = 1'b1; data0 = 32'haaaa5555; out_ready = 1'b0;
        step();
        req0 = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'haaaa5555) begin n_bad++; $display("FAIL mid_hold got=%b/%h exp=1/aaaa5555", out_valid, out_data); end
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_gnt got=%b exp=00", {gnt0, gnt1}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        n_cmp++; if (xfer_count !== 16'd0) begin n_bad++; $display("FAIL mid_count got=%0d exp=0", xfer_count); end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || xfer_count !== 16'd0) begin n_bad++; $display("FAIL mid_noregrant got=%b/%0d exp=0/0", out_valid, xfer_count); end
        // prio must be back at 0: a tie goes to requester 0
        req0 = 1'b1; req1 = 1'b1;
        #1;
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL mid_prio got=%b exp=10", {gnt0, gnt1}); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0; req0 = 1'b1; data0 = 32'h1; out_ready = 1'b1;
        // first edge loads, each later edge completes one transfer
        repeat (65536) @(posedge clk);
        #1;
        n_cmp++; if (xfer_count !== 16'hffff) begin n_bad++; $display("FAIL wrap_pre got=%h exp=ffff", xfer_count); end
        step();
        n_cmp++; if (xfer_count !== 16'h0000) begin n_bad++; $display("FAIL wrap got=%h exp=0000", xfer_count); end
        req0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 SHALL have parameter: N, 32, data width of each requester and of the output port.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req0  input  1  requester 0 has a word to send.
REQ-005 SHALL have port: data0  input  N  requester 0 payload.
REQ-006 SHALL have port: gnt0  output  1  requester 0 word accepted this cycle.
REQ-007 SHALL have port: req1  input  1  requester 1 has a word to send.
REQ-008 SHALL have port: data1  input  N  requester 1 payload.
REQ-009 SHALL have port: gnt1  output  1  requester 1 word accepted this cycle.
REQ-010 SHALL have port: out_valid  output  1  out_data holds an undelivered word.
REQ-011 SHALL have port: out_data  output  N  registered payload toward the shared consumer.
REQ-012 SHALL have port: out_ready  input  1  consumer takes out_data this cycle if out_valid.
REQ-013 SHALL have port: owner  output  1  index of the requester whose word is in out_data.
REQ-014 SHALL have port: xfer_count  output  16  number of completed output transfers, modulo 2^16.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-016 SHALL define accept = (state==IDLE or out_ready) and (req0 or req1); an accept loads a new word in this same cycle.
REQ-017 SHALL choose the winner as: only one req high -> that requester; both high -> the requester indicated by priority pointer prio.
REQ-018 SHALL drive gntK = accept and (winner==K), combinationally from the current req*, out_ready, state and prio, with at most one gnt high per cycle.
REQ-019 SHALL, on accept, register out_data <= winner's data (selected by mux2 with sel=winner), owner <= winner, prio <= not winner, state <= HOLD.
REQ-020 SHALL, in HOLD with out_ready=1 and no req, go to IDLE next cycle; out_data and owner keep their last values.
REQ-021 SHALL, in HOLD with out_ready=0, hold out_data, owner and out_valid stable and assert no gnt.
REQ-022 SHALL sustain one transfer per cycle when out_ready stays high and requests are continuous (back-to-back HOLD->HOLD).
REQ-023 SHALL increment xfer_count on every cycle with out_valid and out_ready both high; it wraps from 16'hFFFF to 0.
REQ-024 SHALL ignore out_ready while in IDLE, with no count increment.
REQ-025 SHALL leave prio unchanged on any cycle with no accept.
REQ-026 Requesters SHALL hold req and data stable until their gnt; the arbiter SHALL NOT latch a request without gnt.

Reset
REQ-027 SHALL, on rst high at a clock edge, set state=IDLE, out_valid=0, out_data=0, owner=0, prio=0 (requester 0 favored), xfer_count=0.
REQ-028 SHALL hold gnt0=gnt1=0 while rst is high, regardless of req.
REQ-029 SHALL drop any word pending in HOLD on reset mid-transfer; it is neither counted nor re-granted.

Structure
REQ-030 SHALL take the FSM state typedef (IDLE, HOLD) and the 16-bit count width constant from the shared package arb_pkg.
REQ-031 SHALL instantiate the existing mux2 (x=data0, y=data1, sel=winner; sel=0 passes x, sel=1 passes y) for payload selection.
REQ-032 Total RTL SHALL stay within 120-400 lines, with no additional sub-modules.

Verification
REQ-033 Reset check: rst=1 for 2 cycles, req0=req1=1 -> gnt0=gnt1=0, out_valid=0, out_data=0, xfer_count=0.
REQ-034 Single requester: req0=1, data0=32'hcafebabe, out_ready=1 -> gnt0 in the first cycle; the next cycle out_valid=1, out_data=32'hcafebabe, owner=0; xfer_count=1 after that cycle.
REQ-035 Contention: req0=req1=1, data1=32'hdeadbeef, out_ready=1 for 4 cycles after reset -> grants alternate 0,1,0,1; out_data sequence cafebabe, deadbeef, cafebabe, deadbeef.
REQ-036 Backpressure: HOLD with out_ready=0 for 5 cycles and req1=1 -> no gnt; out_data stable; out_ready=1 -> gnt1 in that cycle and the new word the next cycle.
REQ-037 Counter wrap: preload 65535 transfers (or force count=16'hFFFF), then one transfer -> xfer_count=0.
REQ-038 Mid-reset: rst asserted in HOLD with out_ready=0 -> next cycle out_valid=0, prio=0, count unchanged at 0 after reset, and the dropped word is not regranted.
